// File: rtl/ram_read_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_read_master_if
// Desc     : Client request/response and AR/R line-read channel bundle.
// Revision : 1.0
// ============================================================================
interface ram_read_master_if #(
   parameter int DW = 128,
   parameter int AW = 16,
   parameter int WW = 32
);
   logic          reqValid;
   logic          reqReady;
   logic [AW-1:0] reqAddr;
   logic          respValid;
   logic          respReady;
   logic [WW-1:0] respData;
   logic          flush;
   logic          arValid;
   logic          arReady;
   logic [AW-1:0] arAddr;
   logic          rValid;
   logic          rReady;
   logic [DW-1:0] rData;
   logic [31:0]   hitCnt;
   logic [31:0]   missCnt;

   modport master (
      input  reqValid, reqAddr, respReady, flush, arReady, rValid, rData,
      output reqReady, respValid, respData, arValid, arAddr, rReady, hitCnt, missCnt
   );

   modport slave (
      output reqValid, reqAddr, respReady, flush, arReady, rValid, rData,
      input  reqReady, respValid, respData, arValid, arAddr, rReady, hitCnt, missCnt
   );
endinterface
`default_nettype wire

// File: rtl/ram_read_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_read_master
// Desc     : Word read initiator issuing aligned single-beat line reads.
//            Optional one-line buffer: define RAM_READ_MASTER_LINE_BUF_EN.
// Revision : 1.0
// ============================================================================
module ram_read_master #(
   parameter int DW = 128,
   parameter int AW = 16,
   parameter int WW = 32
) (
   input  wire logic         clk,
   input  wire logic         rst,
   ram_read_master_if.master bus
);
   localparam int BW = $clog2(DW >> 3);
   localparam int OW = $clog2(WW >> 3);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:OW]  r_addr;
   logic [WW-1:0]   r_resp_data;
   logic [31:0]     r_miss_cnt;
   logic            w_req_hs;
   logic            w_r_hs;
   logic            w_hit;
   logic [WW-1:0]   w_hit_word;
   logic            w_unused_addr;

   function automatic logic [WW-1:0] f_sel(input logic [DW-1:0] line,
                                           input logic [BW-OW-1:0] idx);
      return line[WW*int'(idx) +: WW];
   endfunction

   assign w_req_hs      = (r_state == S_IDLE) && bus.reqValid;
   assign w_r_hs        = (r_state == S_R) && bus.rValid;
   assign w_unused_addr = ^bus.reqAddr[OW-1:0];

`ifdef RAM_READ_MASTER_LINE_BUF_EN
   logic [DW-1:0]  r_line_data;
   logic [AW-1:BW] r_line_tag;
   logic           r_line_valid;
   logic [31:0]    r_hit_cnt;

   // A flush arriving with the request forces the miss path.
   assign w_hit      = r_line_valid && !bus.flush && (r_line_tag == bus.reqAddr[AW-1:BW]);
   assign w_hit_word = f_sel(r_line_data, bus.reqAddr[BW-1:OW]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_line_data  <= '0;
         r_line_tag   <= '0;
         r_line_valid <= 1'b0;
         r_hit_cnt    <= '0;
      end else begin
         if (w_r_hs) begin
            r_line_data <= bus.rData;
            r_line_tag  <= r_addr[AW-1:BW];
         end
         if (bus.flush)
            r_line_valid <= 1'b0;
         else if (w_r_hs)
            r_line_valid <= 1'b1;
         if (w_req_hs && w_hit && (r_hit_cnt != 32'hFFFF_FFFF))
            r_hit_cnt <= r_hit_cnt + 32'd1;
      end
   end

   assign bus.hitCnt = r_hit_cnt;
`else
   logic w_unused_flush;

   assign w_hit          = 1'b0;
   assign w_hit_word     = '0;
   assign w_unused_flush = bus.flush;
   assign bus.hitCnt     = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (bus.reqValid)  w_state_nxt = w_hit ? S_RESP : S_AR;
         S_AR:   if (bus.arReady)   w_state_nxt = S_R;
         S_R:    if (bus.rValid)    w_state_nxt = S_RESP;
         S_RESP: if (bus.respReady) w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= '0;
         r_resp_data <= '0;
         r_miss_cnt  <= '0;
      end else begin
         if (w_req_hs)
            r_addr <= bus.reqAddr[AW-1:OW];
         if (w_req_hs && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF))
            r_miss_cnt <= r_miss_cnt + 32'd1;
         // Response word is captured once and held through RESP backpressure.
         if (w_req_hs && w_hit)
            r_resp_data <= w_hit_word;
         else if (w_r_hs)
            r_resp_data <= f_sel(bus.rData, r_addr[BW-1:OW]);
      end
   end

   assign bus.reqReady  = (r_state == S_IDLE);
   assign bus.arValid   = (r_state == S_AR);
   assign bus.arAddr    = (r_state == S_AR) ? {r_addr[AW-1:BW], {BW{1'b0}}} : '0;
   assign bus.rReady    = (r_state == S_R);
   assign bus.respValid = (r_state == S_RESP);
   assign bus.respData  = r_resp_data;
   assign bus.missCnt   = r_miss_cnt;

endmodule
`default_nettype wire
